// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  localparam int unsigned FETCH_DATA_WIDTH = 32;
  localparam logic [31:0] FETCH_RESET_PC   = 32'h0040_0000;
  localparam int unsigned FETCH_TIMEOUT    = 15;

  typedef enum logic [2:0] {
    RESET   = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } fetchState_e;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JREG   = 2'd3
  } nextPcSel_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the instruction sitting in decode.
module next_pc_logic
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] pcPlus4,
  input  logic                  branchEq,
  input  logic                  branchNe,
  input  logic                  jump,
  input  logic                  jumpSrc,
  input  logic                  zero,
  input  logic [15:0]           branchImm,
  input  logic [25:0]           jumpTarget,
  input  logic [DATA_WIDTH-1:0] rsData,
  output logic [DATA_WIDTH-1:0] nextPc,
  output logic                  misaligned
);

  nextPcSel_e            pcSel;
  logic [DATA_WIDTH-1:0] branchOffset;

  assign branchOffset = {{(DATA_WIDTH-18){branchImm[15]}}, branchImm, 2'b00};

  // Priority: register jump, direct jump, taken branch, then sequential.
  always_comb begin
    pcSel = SEQ;
    if (jump && jumpSrc) begin
      pcSel = JREG;
    end else if (jump) begin
      pcSel = JUMP;
    end else if ((branchEq && zero) || (branchNe && !zero)) begin
      pcSel = BRANCH;
    end
  end

  // Target mux; jr targets are forced word aligned and flagged if they were not.
  always_comb begin
    nextPc     = pcPlus4;
    misaligned = 1'b0;
    case (pcSel)
      BRANCH: nextPc = pcPlus4 + branchOffset;
      JUMP:   nextPc = {pcPlus4[DATA_WIDTH-1:28], jumpTarget, 2'b00};
      JREG: begin
        nextPc     = rsData & ~DATA_WIDTH'(3);
        misaligned = (rsData[1:0] != 2'b00);
      end
      default: nextPc = pcPlus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, decode hold.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RESET   | held in reset; all outputs zero, pc = RESET_PC
// FETCH   | one-cycle imem_req with imem_addr = pc; timer loaded
// WAIT    | request outstanding; latch instruction on imem_valid
// HOLD    | instr_valid high until decode accepts or a flush arrives
// DISCARD | flushed while a request is outstanding; drop its return
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC,
  parameter int unsigned           TIMEOUT    = FETCH_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  instr_valid,
  input  logic                  decode_ready,
  input  logic                  BranchEQ,
  input  logic                  BranchNE,
  input  logic                  Jump,
  input  logic                  JumpSrc,
  input  logic                  zero,
  input  logic [15:0]           branch_imm,
  input  logic [25:0]           jump_target,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] flush_pc,
  output logic                  align_error,
  output logic                  fetch_timeout
);

  localparam int unsigned      TIMER_W    = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT - 1);

  fetchState_e           state;
  fetchState_e           nextState;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] nextPc;
  logic [TIMER_W-1:0]    timer;
  logic                  timerDone;
  logic                  timeoutHit;
  logic                  misaligned;
  logic                  accept;
  logic                  flushActive;

  assign timerDone   = (timer == '0);
  assign timeoutHit  = ((state == WAIT) || (state == DISCARD)) && !imem_valid && timerDone;
  assign flushActive = flush && (state != RESET);
  assign accept      = (state == HOLD) && decode_ready && !flush;

  next_pc_logic #(.DATA_WIDTH(DATA_WIDTH)) u_nextPc (
    .pcPlus4    (pc_plus4),
    .branchEq   (BranchEQ),
    .branchNe   (BranchNE),
    .jump       (Jump),
    .jumpSrc    (JumpSrc),
    .zero       (zero),
    .branchImm  (branch_imm),
    .jumpTarget (jump_target),
    .rsData     (rs_data),
    .nextPc     (nextPc),
    .misaligned (misaligned)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: a flush only parks in DISCARD while a return is still owed.
  always_comb begin
    nextState = state;
    case (state)
      RESET:   nextState = FETCH;
      FETCH:   nextState = flush ? DISCARD : WAIT;
      WAIT: begin
        if (flush) begin
          nextState = imem_valid ? FETCH : DISCARD;
        end else if (imem_valid) begin
          nextState = HOLD;
        end else if (timerDone) begin
          nextState = FETCH;
        end
      end
      HOLD:    if (flush || decode_ready) nextState = FETCH;
      DISCARD: if (imem_valid || timerDone) nextState = FETCH;
      default: nextState = RESET;
    endcase
  end

  // Outputs decoded from state and registered pc only.
  always_comb begin
    imem_req    = (state == FETCH);
    imem_addr   = '0;
    instr_valid = (state == HOLD);
    if (state == FETCH) begin
      imem_addr = pc;
    end
  end

  // PC, instruction register, wait timer and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_PC;
      instr         <= '0;
      instr_pc      <= '0;
      pc_plus4      <= '0;
      timer         <= '0;
      align_error   <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      align_error <= accept && misaligned;
      if (timeoutHit) begin
        fetch_timeout <= 1'b1;
      end
      if (state == FETCH) begin
        timer <= TIMER_LOAD;
      end else if (((state == WAIT) || (state == DISCARD)) && !timerDone) begin
        timer <= timer - TIMER_W'(1);
      end
      if ((state == WAIT) && imem_valid && !flush) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
        pc_plus4 <= pc + DATA_WIDTH'(4);
      end
      if (flushActive) begin
        pc <= flush_pc & ~DATA_WIDTH'(3);
      end else if (accept) begin
        pc <= nextPc;
      end
    end
  end

endmodule
